// File: rtl/ic_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ic_fetch_queue                                                  |
// | Purpose  : Instruction fetch unit. Issues block-aligned I-cache requests,  |
// |            queues the returned instructions with their PCs and hands them  |
// |            to decode. Handles pipeline redirects, including dropping a     |
// |            response that was already in flight.                            |
// | Options  : define IC_FETCH_PERF_EN to build the performance counters;      |
// |            without it perf_stall_cnt and perf_redirect_cnt are tied to 0.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ic_fetch_queue #(
  parameter int              ADDR        = 32,
  parameter int              INST        = 32,
  parameter int              FETCH_WIDTH = 2,
  parameter int              DEPTH       = 8,
  parameter logic [ADDR-1:0] RESET_PC    = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        ic_req_valid,
  output logic [ADDR-1:0]             ic_req_addr,
  input  logic                        ic_req_ready,
  input  logic                        ic_resp_valid,
  input  logic [INST*FETCH_WIDTH-1:0] ic_resp_inst,
  input  logic                        redirect_valid,
  input  logic [ADDR-1:0]             redirect_pc,
  output logic                        dec_valid,
  input  logic                        dec_ready,
  output logic [INST-1:0]             dec_inst,
  output logic [ADDR-1:0]             dec_pc,
  output logic [31:0]                 perf_stall_cnt,
  output logic [31:0]                 perf_redirect_cnt
);

  localparam int INST_BYTES = INST / 8;
  localparam int BLK_BYTES  = FETCH_WIDTH * INST_BYTES;
  localparam int INST_SHIFT = $clog2(INST_BYTES);
  localparam int PTR_W      = $clog2(DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  logic [1:0]       state;
  logic [ADDR-1:0]  fetch_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [INST-1:0]  mem_inst [DEPTH];
  logic [ADDR-1:0]  mem_pc   [DEPTH];

  logic [ADDR-1:0]  blk_base;
  logic [CNT_W-1:0] slot_off;
  logic [CNT_W-1:0] push_amt;
  logic [CNT_W-1:0] free_cnt;
  logic             can_req;
  logic             push;
  logic             pop;

  // Block base and the slot the fetch PC points into; slots below it are skipped.
  assign blk_base = fetch_pc & ~ADDR'(BLK_BYTES - 1);
  assign slot_off = CNT_W'((fetch_pc & ADDR'(BLK_BYTES - 1)) >> INST_SHIFT);
  assign free_cnt = CNT_W'(DEPTH) - count;
  // Space is reserved before requesting, so a response can never overflow.
  assign can_req  = free_cnt >= CNT_W'(FETCH_WIDTH);
  // A redirect always wins over a returning block, so the block is dropped.
  assign push     = (state == WAIT) && ic_resp_valid && !redirect_valid;
  assign push_amt = push ? (CNT_W'(FETCH_WIDTH) - slot_off) : '0;
  assign pop      = dec_valid && dec_ready;

  // A redirect withdraws the request in the same cycle so the cache never sees it.
  assign ic_req_valid = (state == REQ) && !redirect_valid;
  assign ic_req_addr  = ic_req_valid ? blk_base : '0;

  assign dec_valid = (count != '0);
  assign dec_inst  = dec_valid ? mem_inst[rd_ptr] : '0;
  assign dec_pc    = dec_valid ? mem_pc[rd_ptr]   : '0;

  // Fetch state machine and fetch PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
      end else if (push) begin
        fetch_pc <= blk_base + ADDR'(BLK_BYTES);
      end
      case (state)
        IDLE: if (!redirect_valid && can_req) state <= REQ;
        REQ: begin
          if (redirect_valid)    state <= IDLE;
          else if (ic_req_ready) state <= WAIT;
        end
        WAIT: begin
          // Redirect with no data yet: the in-flight block must still be swallowed.
          if (redirect_valid)     state <= ic_resp_valid ? IDLE : DROP;
          else if (ic_resp_valid) state <= IDLE;
        end
        DROP: if (ic_resp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Queue pointers and occupancy; a redirect flushes and overrides any pop.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) wr_ptr <= wr_ptr + push_amt[PTR_W-1:0];
      count <= count + push_amt - CNT_W'(pop);
    end
  end

  // Queue storage: write the useful slots of a returned block in slot order.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (CNT_W'(k) >= slot_off) begin
          mem_inst[wr_ptr + PTR_W'(k) - slot_off[PTR_W-1:0]] <= ic_resp_inst[k*INST +: INST];
          mem_pc[wr_ptr + PTR_W'(k) - slot_off[PTR_W-1:0]]   <= blk_base + ADDR'(k * INST_BYTES);
        end
      end
    end
  end

`ifdef IC_FETCH_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] redir_cnt;

  // Saturating counters: stalled idle cycles and redirect cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      redir_cnt <= '0;
    end else begin
      if ((state == IDLE) && !can_req && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (redirect_valid && (redir_cnt != '1))               redir_cnt <= redir_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt    = stall_cnt;
  assign perf_redirect_cnt = redir_cnt;
`else
  assign perf_stall_cnt    = '0;
  assign perf_redirect_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ic_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ic_fetch_queue                                               |
// | Purpose  : Self-checking bench for ic_fetch_queue: directed sequences, a   |
// |            vector table of redirect/response cases and a randomized run    |
// |            against an expected-PC-stream reference model.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ic_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_req_ready;
  logic        ic_resp_valid;
  logic [63:0] ic_resp_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_redirect_cnt;

  int total = 0;
  int bad   = 0;
  int redirects = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] exp_addr;
    int          exp_n;
    logic [31:0] exp_i0;
  } vec_t;

  vec_t vt [6];

  // Random-phase state.
  logic [31:0] exp_pc;
  logic [31:0] paddr;
  logic [31:0] rpc;
  logic [31:0] s0;
  logic        rd;
  logic        pend;
  int          cd;
  int          pops;
  int          nreq;

  ic_fetch_queue #(
    .ADDR(32), .INST(32), .FETCH_WIDTH(2), .DEPTH(8), .RESET_PC(32'h100)
  ) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_inst(ic_resp_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc),
    .perf_stall_cnt(perf_stall_cnt), .perf_redirect_cnt(perf_redirect_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1);
  end

  function automatic logic [31:0] f(input logic [31:0] pc);
    return {~pc[15:0], pc[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    #1;
    while (!ic_req_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("req_seen", {31'd0, ic_req_valid}, 32'd1);
  endtask

  task automatic accept();
    ic_req_ready = 1'b1;
    @(negedge clk);
    ic_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d0, input logic [31:0] d1);
    ic_resp_valid = 1'b1;
    ic_resp_inst  = {d1, d0};
    @(negedge clk);
    ic_resp_valid = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    redirects++;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic chk_perf_redir();
`ifdef IC_FETCH_PERF_EN
    chk("perf_redirect", perf_redirect_cnt, redirects);
`else
    chk("perf_redirect_off", perf_redirect_cnt, 32'd0);
`endif
  endtask

  initial begin
    vt[0] = '{32'h20C,      32'hC,  32'hD,  32'h208,      1, 32'hD};
    vt[1] = '{32'h300,      32'h11, 32'h22, 32'h300,      2, 32'h11};
    vt[2] = '{32'h404,      32'h33, 32'h44, 32'h400,      1, 32'h44};
    vt[3] = '{32'h1000,     32'h55, 32'h66, 32'h1000,     2, 32'h55};
    vt[4] = '{32'hFFFFFFFC, 32'h77, 32'h88, 32'hFFFFFFF8, 1, 32'h88};
    vt[5] = '{32'h8,        32'h99, 32'hAA, 32'h8,        2, 32'h99};

    reset = 1'b1; ic_req_ready = 1'b0; ic_resp_valid = 1'b0; ic_resp_inst = '0;
    redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_req_valid", {31'd0, ic_req_valid}, 32'd0);
    chk("rst_req_addr", ic_req_addr, 32'd0);
    chk("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    chk("rst_dec_inst", dec_inst, 32'd0);
    chk("rst_dec_pc", dec_pc, 32'd0);
    chk("rst_perf_stall", perf_stall_cnt, 32'd0);
    chk("rst_perf_redir", perf_redirect_cnt, 32'd0);
    reset = 1'b0;

    // First fetch from RESET_PC.
    wait_req();
    chk("boot_addr", ic_req_addr, 32'h100);
    accept();
    @(negedge clk);
    respond(32'hA, 32'hB);
    chk("boot_v0", {31'd0, dec_valid}, 32'd1);
    chk("boot_pc0", dec_pc, 32'h100);
    chk("boot_i0", dec_inst, 32'hA);
    dec_ready = 1'b1;
    @(negedge clk);
    chk("boot_pc1", dec_pc, 32'h104);
    chk("boot_i1", dec_inst, 32'hB);
    @(negedge clk);
    dec_ready = 1'b0;
    chk("boot_empty", {31'd0, dec_valid}, 32'd0);

    // Redirect while waiting: stale block must be dropped.
    wait_req();
    chk("seq_addr", ic_req_addr, 32'h108);
    accept();
    do_redirect(32'h400);
    respond(32'hFF, 32'hEE);
    chk("stale_dropped", {31'd0, dec_valid}, 32'd0);
    wait_req();
    chk("drop_addr", ic_req_addr, 32'h400);
    accept();
    respond(32'h1, 32'h2);
    chk("drop_pc", dec_pc, 32'h400);
    chk("drop_inst", dec_inst, 32'h1);
    chk_perf_redir();

    // Redirect coincident with response and pop.
    wait_req();
    chk("pre_coinc_addr", ic_req_addr, 32'h408);
    accept();
    ic_resp_valid = 1'b1; ic_resp_inst = {32'h5, 32'h4};
    redirect_valid = 1'b1; redirect_pc = 32'h600; redirects++;
    dec_ready = 1'b1;
    @(negedge clk);
    ic_resp_valid = 1'b0; redirect_valid = 1'b0; dec_ready = 1'b0;
    #1;
    chk("coinc_flush", {31'd0, dec_valid}, 32'd0);
    wait_req();
    chk("coinc_addr", ic_req_addr, 32'h600);
    accept();
    respond(32'h61, 32'h62);
    chk("coinc_pc", dec_pc, 32'h600);
    chk_perf_redir();

    // Vector table: redirect, request address, delivered slots.
    for (int v = 0; v < 6; v++) begin
      do_redirect(vt[v].pc);
      wait_req();
      chk("vec_addr", ic_req_addr, vt[v].exp_addr);
      accept();
      @(negedge clk);
      respond(vt[v].d0, vt[v].d1);
      for (int i = 0; i < vt[v].exp_n; i++) begin
        chk("vec_valid", {31'd0, dec_valid}, 32'd1);
        chk("vec_pc", dec_pc, vt[v].pc + 32'(4 * i));
        chk("vec_inst", dec_inst, (i == 0) ? vt[v].exp_i0 : vt[v].d1);
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
      end
      chk("vec_empty", {31'd0, dec_valid}, 32'd0);
    end

    // Back-pressure: decode stalled, cache always ready.
    do_redirect(32'h800);
    nreq = 0; cd = -1; paddr = '0;
    for (int c = 0; c < 60; c++) begin
      ic_resp_valid = 1'b0;
      ic_req_ready  = 1'b1;
      if (cd == 0) begin
        ic_resp_valid = 1'b1;
        ic_resp_inst  = {f(paddr + 32'd4), f(paddr)};
      end
      if (cd >= 0) cd--;
      if (ic_req_valid) begin
        nreq++;
        paddr = ic_req_addr;
        cd = 2;
      end
      @(negedge clk);
    end
    ic_req_ready = 1'b0; ic_resp_valid = 1'b0;
    chk("stall_nreq", nreq, 32'd4);
    chk("stall_req_valid", {31'd0, ic_req_valid}, 32'd0);
    s0 = perf_stall_cnt;
    repeat (10) @(negedge clk);
`ifdef IC_FETCH_PERF_EN
    chk("perf_stall_delta", perf_stall_cnt, s0 + 32'd10);
`else
    chk("perf_stall_off", perf_stall_cnt, 32'd0);
`endif
    dec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("full_pc", dec_pc, 32'h800 + 32'(4 * i));
      chk("full_inst", dec_inst, f(32'h800 + 32'(4 * i)));
      @(negedge clk);
    end
    dec_ready = 1'b0;

    // Randomized run against the expected PC stream.
    pend = 1'b0; cd = 0; pops = 0; exp_pc = '0;
    for (int c = 0; c < 3000; c++) begin
      redirect_valid = 1'b0;
      #1;
      rd  = (c == 0) || ($urandom_range(0, 19) == 0);
      rpc = 32'h2000 + 32'($urandom_range(0, 1023)) * 32'd4;
      ic_resp_valid = 1'b0;
      if (pend && cd == 0) begin
        ic_resp_valid = 1'b1;
        ic_resp_inst  = {f(paddr + 32'd4), f(paddr)};
        pend = 1'b0;
      end else if (pend) begin
        cd--;
      end
      dec_ready = ($urandom_range(0, 3) != 0);
      if (dec_valid && dec_ready && !rd) begin
        chk("rnd_pc", dec_pc, exp_pc);
        chk("rnd_inst", dec_inst, f(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      ic_req_ready = ($urandom_range(0, 1) != 0);
      if (ic_req_valid && ic_req_ready && !rd) begin
        chk("rnd_one_outstanding", {31'd0, pend}, 32'd0);
        chk("rnd_req_align", ic_req_addr & 32'h7, 32'd0);
        pend  = 1'b1;
        paddr = ic_req_addr;
        cd    = $urandom_range(0, 3);
      end
      redirect_valid = rd;
      redirect_pc    = rpc;
      if (rd) begin
        exp_pc = rpc;
        redirects++;
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0; dec_ready = 1'b0; ic_req_ready = 1'b0; ic_resp_valid = 1'b0;
    chk("rnd_progress", {31'd0, pops >= 40}, 32'd1);
    chk_perf_redir();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
